data_mem_backend: RTL and testbench
===================================

Name: data_mem_backend

Overview:
- Word-organised backing data memory for the data cache's memory-interface (MIF) side.
- Consumes the cache's MIF request signals: address, write data, read/write strobes, sign, mem mode.
- Produces read data, a stall handshake and the data-memory LED.
- Models a fixed multi-cycle access latency so the cache's miss/line-fill and write-through paths see realistic stalls.

Parameters:
- MEM_WORDS_LOG2, 10, log2 of the number of 32-bit words stored; the address wraps modulo 4<<MEM_WORDS_LOG2 bytes.
- LATENCY, 4, number of cycles stall_o is high per transaction; legal range 1..15.

Ports:
- clock_i  in  1  clock; all state changes on the rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- address_i  in  `ALU_OP_SIZE  byte address of the request.
- data_i  in  `GPR_SIZE  write data, right-aligned.
- write_data_i  in  1  write request.
- read_data_i  in  1  read request.
- sign_i  in  1  1 = zero-extend (unsigned), 0 = sign-extend; reads only.
- mem_mode_i  in  `MEM_MODE_SIZE  `MEMMODE_BYTE / `MEMMODE_HALF / `MEMMODE_WORD.
- read_data_o  out  `MEM_DATA_SIZE  extended read result.
- stall_o  out  1  transaction in progress.
- dm_led_o  out  1  toggles on each completed write.
- err_o  out  1  sticky misalignment flag (see Optional Feature).

Behaviour:
- Reset (async, reset_n_i=0):
  - state=IDLE, counter=0.
  - read_data_o=0, stall_o=0, dm_led_o=0, err_o=0.
  - Memory array contents are not cleared.
  - Reset mid-transaction aborts it: no write is committed and read_data_o returns to 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If read_data_i or write_data_i is high, stall_o=1 combinationally in that same cycle.
  - On the next edge, latch address, data, strobes, sign and mode.
  - If LATENCY==1, perform the access and go to DONE.
  - Otherwise load counter with LATENCY-1 and go to BUSY.
  - With no request: stall_o=0 and read_data_o holds its value.
- BUSY:
  - stall_o=1; the counter decrements each edge.
  - On the edge where the counter equals 1, perform the access using the latched values and go to DONE.
  - Input changes during BUSY are ignored.
- DONE:
  - stall_o=0; read_data_o is valid (reads).
  - Next edge goes to IDLE unconditionally; the request still visible in DONE is treated as the completed one.
  - A request seen in the following IDLE cycle is a new transaction.
  - Net timing: stall_o is high for exactly LATENCY cycles from the request cycle, then low for one cycle.
- Simultaneous read and write: write wins, read is ignored, and read_data_o is unchanged.
- Word index = address[MEM_WORDS_LOG2+1:2]; higher address bits are ignored (wrap-around). Little-endian lanes.
- Writes:
  - BYTE replaces lane address[1:0] with data_i[7:0].
  - HALF replaces lanes {address[1],0} and {address[1],1} with data_i[15:0].
  - WORD replaces the whole word.
  - Other lanes are preserved.
  - Any other mode value: no write.
  - dm_led_o toggles at the commit edge.
- Reads:
  - Select the byte or half from the addressed lanes, then extend to 32 bits per sign_i.
  - WORD returns the word unmodified.
  - Any other mode value returns 32'd123.
- Misalignment without the feature: HALF ignores address[0]; WORD ignores address[1:0].

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined, a misaligned access (HALF with address[0]=1, or WORD with address[1:0]!=0):
  - completes with normal LATENCY timing;
  - commits no write;
  - returns read_data_o=0 and does not toggle dm_led_o;
  - sets err_o=1, which stays high until reset.
- When undefined, err_o is tied to 0 and the alignment-forcing rule above applies.

Test Plan:
- LATENCY=4; write WORD 0xDEADBEEF @0x40 → stall_o high 4 cycles from the request cycle, then low 1 cycle; dm_led_o 0→1; a later read WORD @0x40 returns 0xDEADBEEF after 4 stall cycles.
- Write BYTE 0x80 @0x41 over word 0x11223344 → word becomes 0x11228044; read BYTE @0x41 with sign=0 gives 0xFFFFFF80, with sign=1 gives 0x00000080.
- Eight back-to-back WORD reads @0x00,0x04,…,0x1C, each address presented in the cycle after DONE → eight transactions, each 4 stall cycles, in-order data, no read dropped or duplicated.
- Read and write asserted together @0x10 → only the write commits; read_data_o keeps its prior value.
- reset_n_i=0 during BUSY of a write @0x20 → stall_o drops immediately; memory @0x20 is unchanged; the first request after release completes normally.
- MEM_ALIGN_CHECK_EN defined; HALF write @0x03 → no memory change, err_o=1 sticky; undefined → the write lands at lanes 2-3.

Source files
------------

// File: rtl/data_mem_backend.sv
// data_mem_backend: word-organised backing data memory with fixed-latency stall handshake (optional MEM_ALIGN_CHECK_EN misalignment trap)
`ifndef ALU_OP_SIZE
`define ALU_OP_SIZE 32
`endif
`ifndef GPR_SIZE
`define GPR_SIZE 32
`endif
`ifndef MEM_DATA_SIZE
`define MEM_DATA_SIZE 32
`endif
`ifndef MEM_MODE_SIZE
`define MEM_MODE_SIZE 2
`endif
`ifndef MEMMODE_BYTE
`define MEMMODE_BYTE 2'd0
`endif
`ifndef MEMMODE_HALF
`define MEMMODE_HALF 2'd1
`endif
`ifndef MEMMODE_WORD
`define MEMMODE_WORD 2'd2
`endif

module data_mem_backend #(
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int LATENCY        = 4
) (
  input  logic                        clock_i,
  input  logic                        reset_n_i,
  input  logic [`ALU_OP_SIZE-1:0]     address_i,
  input  logic [`GPR_SIZE-1:0]        data_i,
  input  logic                        write_data_i,
  input  logic                        read_data_i,
  input  logic                        sign_i,
  input  logic [`MEM_MODE_SIZE-1:0]   mem_mode_i,
  output logic [`MEM_DATA_SIZE-1:0]   read_data_o,
  output logic                        stall_o,
  output logic                        dm_led_o,
  output logic                        err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] LOAD = 4'(LATENCY - 1);
  localparam bit         ONE  = (LATENCY == 1);

  state_t                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [`ALU_OP_SIZE-1:0]     addr_q, addr_d;
  logic [`GPR_SIZE-1:0]        data_q, data_d;
  logic                        wr_q, wr_d, rd_q, rd_d, sign_q, sign_d;
  logic [`MEM_MODE_SIZE-1:0]   mode_q, mode_d;
  logic [31:0]                 rdata_q, rdata_d;
  logic                        led_q, led_d, err_q, err_d;
  logic [31:0]                 mem_q [1<<MEM_WORDS_LOG2];

  logic                        req, live, commit, mem_we, mis, bad;
  logic                        a_wr, a_rd, a_sign;
  logic [`ALU_OP_SIZE-1:0]     a_addr;
  logic [`GPR_SIZE-1:0]        a_data;
  logic [`MEM_MODE_SIZE-1:0]   a_mode;
  logic [MEM_WORDS_LOG2-1:0]   a_idx;
  logic [1:0]                  lane;
  logic [4:0]                  sh;
  logic [31:0]                 a_word, wmask, mem_wdata, sel, ext;
  logic                        unused_hi;

  assign req       = read_data_i | write_data_i;
  assign unused_hi = ^a_addr[`ALU_OP_SIZE-1:MEM_WORDS_LOG2+2];

  // Access datapath: live inputs when committing straight from IDLE, latched request otherwise
  always_comb begin
    live      = state_q == IDLE;
    a_addr    = live ? address_i : addr_q;
    a_data    = live ? data_i : data_q;
    a_wr      = live ? write_data_i : wr_q;
    a_rd      = live ? read_data_i : rd_q;
    a_sign    = live ? sign_i : sign_q;
    a_mode    = live ? mem_mode_i : mode_q;
    a_idx     = a_addr[MEM_WORDS_LOG2+1:2];
    a_word    = mem_q[a_idx];
`ifdef MEM_ALIGN_CHECK_EN
    mis       = (a_mode == `MEMMODE_HALF && a_addr[0]) || (a_mode == `MEMMODE_WORD && a_addr[1:0] != 2'd0);
`else
    mis       = 1'b0;
`endif
    bad       = !(a_mode == `MEMMODE_BYTE || a_mode == `MEMMODE_HALF || a_mode == `MEMMODE_WORD);
    lane      = a_mode == `MEMMODE_HALF ? {a_addr[1], 1'b0} : a_mode == `MEMMODE_WORD ? 2'd0 : a_addr[1:0];
    sh        = {lane, 3'b000};
    wmask     = (a_mode == `MEMMODE_BYTE ? 32'hFF : a_mode == `MEMMODE_HALF ? 32'hFFFF : 32'hFFFF_FFFF) << sh;
    mem_wdata = (a_word & ~wmask) | ((32'(a_data) << sh) & wmask);
    sel       = a_word >> sh;
    ext       = a_mode == `MEMMODE_BYTE ? {{24{~a_sign & sel[7]}}, sel[7:0]} :
                a_mode == `MEMMODE_HALF ? {{16{~a_sign & sel[15]}}, sel[15:0]} :
                a_mode == `MEMMODE_WORD ? a_word : 32'd123;
    commit    = reset_n_i && (state_q == BUSY ? cnt_q == 4'd1 : live && req && ONE);
    mem_we    = commit && a_wr && !bad && !mis;
  end

  // Next-state, request latching, stall and commit side effects
  always_comb begin
    state_d = state_q == IDLE ? (req ? (ONE ? DONE : BUSY) : IDLE) :
              state_q == BUSY ? (cnt_q == 4'd1 ? DONE : BUSY) : IDLE;
    cnt_d   = state_q == BUSY ? cnt_q - 4'd1 : LOAD;
    stall_o = state_q == IDLE ? req : state_q == BUSY;
    addr_d  = live && req ? address_i : addr_q;
    data_d  = live && req ? data_i : data_q;
    wr_d    = live && req ? write_data_i : wr_q;
    rd_d    = live && req ? read_data_i : rd_q;
    sign_d  = live && req ? sign_i : sign_q;
    mode_d  = live && req ? mem_mode_i : mode_q;
    led_d   = led_q ^ mem_we;
    err_d   = err_q | (commit & mis);
    rdata_d = !commit ? rdata_q : mis ? 32'd0 : (a_rd && !a_wr) ? ext : rdata_q;
  end

  // Control and request registers; reset aborts any transaction in flight
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      sign_q  <= 1'b0;
      mode_q  <= '0;
      rdata_q <= 32'd0;
      led_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      sign_q  <= sign_d;
      mode_q  <= mode_d;
      rdata_q <= rdata_d;
      led_q   <= led_d;
      err_q   <= err_d;
    end
  end

  // Storage array keeps its contents across reset
  always_ff @(posedge clock_i) begin
    if (mem_we) mem_q[a_idx] <= mem_wdata;
  end

  assign read_data_o = `MEM_DATA_SIZE'(rdata_q);
  assign dm_led_o    = led_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_data_mem_backend.sv
// tb_data_mem_backend: directed table, corner sequences and random traffic against a byte-level memory model
module tb_data_mem_backend;
  localparam int L = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    bit          w;
    bit          r;
    bit          s;
    logic [1:0]  m;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 0, rst_n = 0;
  logic [31:0] addr = 0, din = 0, dout;
  logic        wr = 0, rd = 0, sg = 0;
  logic [1:0]  md = 0;
  logic        stall, led, err;

  int          vectors = 0, miscompares = 0;
  logic [7:0]  mb [4096];
  logic [31:0] m_rd = 0, last_rd = 0;
  logic        m_led = 0, m_err = 0;
  vec_t        tv [17];

  data_mem_backend #(.MEM_WORDS_LOG2(10), .LATENCY(L)) dut (
    .clock_i(clk), .reset_n_i(rst_n), .address_i(addr), .data_i(din),
    .write_data_i(wr), .read_data_i(rd), .sign_i(sg), .mem_mode_i(md),
    .read_data_o(dout), .stall_o(stall), .dm_led_o(led), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a, input int n, input bit s);
    logic [31:0] base = a & ~(32'(n - 1));
    logic [31:0] v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + 32'(mb[(base + 32'(i)) & 32'hFFF]);
    if (!s && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic model(input logic [31:0] a, input logic [31:0] d, input bit w, input bit r, input bit s, input logic [1:0] m);
    int n = m == 0 ? 1 : m == 1 ? 2 : 4;
    bit mis = 0;
    logic [31:0] base = a & ~(32'(n - 1));
`ifdef MEM_ALIGN_CHECK_EN
    mis = m != 0 && m != 3 && (a % n) != 0;
`endif
    if (mis) begin
      m_err = 1;
      m_rd  = 0;
    end else if (w) begin
      if (m != 3) begin
        for (int i = 0; i < n; i++) mb[(base + 32'(i)) & 32'hFFF] = 8'(d >> (8 * i));
        m_led = ~m_led;
      end
    end else if (r) m_rd = m == 3 ? 32'd123 : mread(a, n, s);
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] d, input bit w, input bit r, input bit s, input logic [1:0] m);
    model(a, d, w, r, s, m);
    addr = a; din = d; wr = w; rd = r; sg = s; md = m;
    #1 chk("stall_req", 32'(stall), 32'd1);
    for (int k = 1; k < L; k++) begin
      @(negedge clk);
      wr = 0; rd = 0; addr = $urandom; din = $urandom; sg = 1'($urandom); md = 2'($urandom);
      #1 chk("stall_busy", 32'(stall), 32'd1);
    end
    @(negedge clk);
    #1 chk("stall_done", 32'(stall), 32'd0);
    chk("read_data", dout, m_rd);
    chk("led", 32'(led), 32'(m_led));
    chk("err", 32'(err), 32'(m_err));
    last_rd = dout;
    @(negedge clk);
  endtask

  initial begin
    tv[0]  = '{32'h40,   32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0};
    tv[1]  = '{32'h40,   32'h0,        1'b0, 1'b1, 1'b0, 2'd2, 32'hDEADBEEF};
    tv[2]  = '{32'h44,   32'h11223344, 1'b1, 1'b0, 1'b0, 2'd2, 32'hDEADBEEF};
    tv[3]  = '{32'h45,   32'h80,       1'b1, 1'b0, 1'b0, 2'd0, 32'hDEADBEEF};
    tv[4]  = '{32'h44,   32'h0,        1'b0, 1'b1, 1'b0, 2'd2, 32'h11228044};
    tv[5]  = '{32'h45,   32'h0,        1'b0, 1'b1, 1'b0, 2'd0, 32'hFFFFFF80};
    tv[6]  = '{32'h45,   32'h0,        1'b0, 1'b1, 1'b1, 2'd0, 32'h00000080};
    tv[7]  = '{32'h44,   32'h0,        1'b0, 1'b1, 1'b0, 2'd0, 32'h00000044};
    tv[8]  = '{32'h46,   32'h0,        1'b0, 1'b1, 1'b0, 2'd1, 32'h00001122};
    tv[9]  = '{32'h42,   32'h8001,     1'b1, 1'b0, 1'b0, 2'd1, 32'h00001122};
    tv[10] = '{32'h42,   32'h0,        1'b0, 1'b1, 1'b0, 2'd1, 32'hFFFF8001};
    tv[11] = '{32'h42,   32'h0,        1'b0, 1'b1, 1'b1, 2'd1, 32'h00008001};
    tv[12] = '{32'h40,   32'h0,        1'b0, 1'b1, 1'b0, 2'd3, 32'h0000007B};
    tv[13] = '{32'h1040, 32'h0,        1'b0, 1'b1, 1'b0, 2'd2, 32'h8001BEEF};
    tv[14] = '{32'h10,   32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 2'd2, 32'h8001BEEF};
    tv[15] = '{32'h10,   32'h0,        1'b0, 1'b1, 1'b0, 2'd2, 32'hCAFEF00D};
    tv[16] = '{32'hFFFFF047, 32'h0,    1'b0, 1'b1, 1'b1, 2'd0, 32'h00000011};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rdata", dout, 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk) rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) txn(32'(i * 4), $urandom, 1'b1, 1'b0, 1'b0, 2'd2);

    for (int i = 0; i < 17; i++) begin
      txn(tv[i].a, tv[i].d, tv[i].w, tv[i].r, tv[i].s, tv[i].m);
      chk($sformatf("vec%0d", i), last_rd, tv[i].exp);
    end
    #1 chk("idle_no_req_stall", 32'(stall), 32'd0);

    for (int i = 0; i < 8; i++) txn(32'(i * 4), 32'h0, 1'b0, 1'b1, 1'b0, 2'd2);

    addr = 32'h20; din = 32'h12345678; wr = 1; rd = 0; md = 2'd2;
    @(negedge clk);
    wr = 0;
    rst_n = 0;
    #1;
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_rdata", dout, 32'd0);
    chk("abort_led", 32'(led), 32'd0);
    m_rd = 0; m_led = 0; m_err = 0;
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    txn(32'h20, 32'h0, 1'b0, 1'b1, 1'b0, 2'd2);

    txn(32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2);
    txn(32'h3, 32'hA5A5, 1'b1, 1'b0, 1'b0, 2'd1);
    txn(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd2);
`ifdef MEM_ALIGN_CHECK_EN
    chk("misalign_half", last_rd, 32'h0);
    chk("misalign_err", 32'(err), 32'd1);
`else
    chk("misalign_half", last_rd, 32'hA5A50000);
    chk("misalign_err", 32'(err), 32'd0);
`endif

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63));
      bit w = $urandom_range(0, 2) == 0;
      bit r = 1'($urandom);
      if (!w && !r) r = 1;
      txn(a, $urandom, w, r, 1'($urandom), w ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
